// File: rtl/memctl_pkg.sv
// Shared types and constants for the memory responder.
// State encodings, the wait-counter width and the default I/O page.
package memctl_pkg;

  localparam int WAIT_W = 4;
  localparam logic [7:0] IO_PAGE_DEFAULT = 8'hFF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    WAIT   = ST_WAIT,
    RESP   = ST_RESP,
    HOLD   = ST_HOLD
  } state_t;

  // The counter reaches zero on the last wait cycle, so it is loaded one short.
  function automatic logic [WAIT_W-1:0] wait_load(input int ws);
    if (ws <= 0) return '0;
    return WAIT_W'(ws - 1);
  endfunction

endpackage

// File: rtl/memctl_wait_ctr.sv
// Loadable down-counter with a zero flag, used to time the WAIT state.
module memctl_wait_ctr
  import memctl_pkg::*;
#(
  parameter int WIDTH = WAIT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one RAM transaction per request with programmable wait states.
// Define MEMCTL_MMIO_EN to map the IO_PAGE address page onto io_in/io_out instead of RAM.
module mem_responder
  import memctl_pkg::*;
#(
  parameter int         DATA_W      = 16,
  parameter int         ADDR_W      = 10,
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] IO_PAGE     = IO_PAGE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              req_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = wait_load(WAIT_STATES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_write_q, op_write_d;
  logic                is_io_q, is_io_d;
  logic                req_err_q, req_err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   resp_data;
  logic                addr_is_io;
  logic                ctr_load, ctr_dec, ctr_zero;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[15:ADDR_W];

`ifdef MEMCTL_MMIO_EN
  logic [DATA_W-1:0]   io_out_q, io_out_d;
  logic [DATA_W-1:0]   io_sample_q, io_sample_d;

  assign addr_is_io = (mem_addr[15:8] == IO_PAGE);
  assign io_out     = io_out_q;
`else
  logic                unused_io_in;
  logic [7:0]          unused_io_page;

  assign addr_is_io     = 1'b0;
  assign io_out         = '0;
  assign unused_io_in   = ^io_in;
  assign unused_io_page = IO_PAGE;
`endif

  memctl_wait_ctr #(.WIDTH(WAIT_W)) u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .dec      (ctr_dec),
    .load_val (WAIT_LOAD),
    .zero     (ctr_zero)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    is_io_d    = is_io_q;
    req_err_d  = req_err_q;
    rdata_d    = rdata_q;
    mem_rdata  = rdata_q;
    mem_ready  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    resp_data  = ram_rdata;
`ifdef MEMCTL_MMIO_EN
    io_out_d    = io_out_q;
    io_sample_d = io_sample_q;
    if (is_io_q) begin
      resp_data = io_sample_q;
    end
`endif

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d     = mem_addr[ADDR_W-1:0];
          wdata_d    = mem_wdata;
          op_write_d = mem_write;
          is_io_d    = addr_is_io;
          if (mem_read && mem_write) begin
            req_err_d = 1'b1;
          end
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (!is_io_q) begin
          ram_en = 1'b1;
          ram_we = op_write_q;
        end
`ifdef MEMCTL_MMIO_EN
        if (is_io_q) begin
          if (op_write_q) begin
            io_out_d = wdata_q;
          end else begin
            io_sample_d = io_in;
          end
        end
`endif
        if (WAIT_STATES != 0) begin
          ctr_load = 1'b1;
          state_d  = WAIT;
        end else begin
          state_d = RESP;
        end
      end

      // RAM stays idle here so its registered output is still valid in RESP.
      WAIT: begin
        if (ctr_zero) begin
          state_d = RESP;
        end else begin
          ctr_dec = 1'b1;
        end
      end

      RESP: begin
        mem_ready = 1'b1;
        if (!op_write_q) begin
          mem_rdata = resp_data;
          rdata_d   = resp_data;
        end
        state_d = HOLD;
      end

      HOLD: begin
        if (!mem_read && !mem_write) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      is_io_q    <= 1'b0;
      req_err_q  <= 1'b0;
      rdata_q    <= '0;
`ifdef MEMCTL_MMIO_EN
      io_out_q    <= '0;
      io_sample_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
      is_io_q    <= is_io_d;
      req_err_q  <= req_err_d;
      rdata_q    <= rdata_d;
`ifdef MEMCTL_MMIO_EN
      io_out_q    <= io_out_d;
      io_sample_q <= io_sample_d;
`endif
    end
  end

  assign req_err   = req_err_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Drives two responders (0 and 3 wait states) with the same requests and
// scoreboards returned data, latency and RAM strobes against a local memory model.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] io_in;

  logic [15:0] mem_rdata_0, mem_rdata_3;
  logic        mem_ready_0, mem_ready_3;
  logic        req_err_0, req_err_3;
  logic        ram_en_0, ram_en_3;
  logic        ram_we_0, ram_we_3;
  logic [9:0]  ram_addr_0, ram_addr_3;
  logic [15:0] ram_wdata_0, ram_wdata_3;
  logic [15:0] ram_rdata_0, ram_rdata_3;
  logic [15:0] io_out_0, io_out_3;

  logic [15:0] ram0 [0:1023];
  logic [15:0] ram3 [0:1023];
  logic [15:0] exp_mem [0:1023];
  logic [15:0] exp_q [$];
  logic [15:0] last_rd;
  logic [9:0]  last_ram_addr;

  int checks;
  int errors;

  mem_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_0),
    .mem_ready(mem_ready_0), .req_err(req_err_0), .ram_en(ram_en_0),
    .ram_we(ram_we_0), .ram_addr(ram_addr_0), .ram_wdata(ram_wdata_0),
    .ram_rdata(ram_rdata_0), .io_in(io_in), .io_out(io_out_0)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_3),
    .mem_ready(mem_ready_3), .req_err(req_err_3), .ram_en(ram_en_3),
    .ram_we(ram_we_3), .ram_addr(ram_addr_3), .ram_wdata(ram_wdata_3),
    .ram_rdata(ram_rdata_3), .io_in(io_in), .io_out(io_out_3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port synchronous RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_en_0) begin
      if (ram_we_0) ram0[ram_addr_0] <= ram_wdata_0;
      ram_rdata_0 <= ram0[ram_addr_0];
    end
    if (ram_en_3) begin
      if (ram_we_3) ram3[ram_addr_3] <= ram_wdata_3;
      ram_rdata_3 <= ram3[ram_addr_3];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input string name, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] wd, input int hold_extra);
    logic [15:0] exp;
    logic [15:0] d0, d3;
    int lat0, lat3, rdy0, rdy3, en0, en3, cyc, exp_en;
    bit is_io;
    is_io = 1'b0;
`ifdef MEMCTL_MMIO_EN
    is_io = (addr[15:8] == 8'hFF);
`endif
    exp_en = is_io ? 0 : 1;
    if (wr) begin
      exp = last_rd;
      if (!is_io) exp_mem[addr[9:0]] = wd;
    end else begin
      exp = is_io ? io_in : exp_mem[addr[9:0]];
      last_rd = exp;
    end
    exp_q.push_back(exp);

    mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
    lat0 = -1; lat3 = -1; rdy0 = 0; rdy3 = 0; en0 = 0; en3 = 0; cyc = 0;
    d0 = 'x; d3 = 'x;
    while (cyc < 30 && (lat0 < 0 || lat3 < 0 || cyc < lat3 + hold_extra)) begin
      @(posedge clk); #1; cyc++;
      if (mem_ready_0) begin rdy0++; if (lat0 < 0) begin lat0 = cyc; d0 = mem_rdata_0; end end
      if (mem_ready_3) begin rdy3++; if (lat3 < 0) begin lat3 = cyc; d3 = mem_rdata_3; end end
      if (ram_en_0) begin en0++; last_ram_addr = ram_addr_0; end
      if (ram_en_3) en3++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_ready_0) rdy0++;
      if (mem_ready_3) rdy3++;
      if (ram_en_0) en0++;
      if (ram_en_3) en3++;
    end

    exp = exp_q.pop_front();
    check({name, " latency ws0"}, lat0, 2);
    check({name, " latency ws3"}, lat3, 5);
    check({name, " ready pulses ws0"}, rdy0, 1);
    check({name, " ready pulses ws3"}, rdy3, 1);
    check({name, " ram_en cycles ws0"}, en0, exp_en);
    check({name, " ram_en cycles ws3"}, en3, exp_en);
    check({name, " rdata ws0"}, d0, exp);
    check({name, " rdata ws3"}, d3, exp);
  endtask

  initial begin
    checks = 0; errors = 0;
    last_rd = '0; last_ram_addr = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    io_in = 16'h5A5A;
    for (int i = 0; i < 1024; i++) begin
      ram0[i] = 16'h0000; ram3[i] = 16'h0000; exp_mem[i] = 16'h0000;
    end
    ram0[10'h3FF] = 16'hBEEF; ram3[10'h3FF] = 16'hBEEF; exp_mem[10'h3FF] = 16'hBEEF;
    ram_rdata_0 = '0; ram_rdata_3 = '0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset mem_ready", {mem_ready_0, mem_ready_3}, 0);
    check("reset ram_en", {ram_en_0, ram_en_3, ram_we_0, ram_we_3}, 0);
    check("reset req_err", {req_err_0, req_err_3}, 0);
    check("reset mem_rdata", {mem_rdata_0, mem_rdata_3}, 0);
    check("reset ram_addr", {ram_addr_0, ram_addr_3}, 0);
    check("reset ram_wdata", {ram_wdata_0, ram_wdata_3}, 0);
    check("reset io_out", {io_out_0, io_out_3}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_txn("write 0x0005", 1'b0, 1'b1, 16'h0005, 16'h1234, 0);
    do_txn("read 0x0005", 1'b1, 1'b0, 16'h0005, 16'h0000, 0);
    do_txn("read 0x03FF", 1'b1, 1'b0, 16'h03FF, 16'h0000, 0);

    do_txn("write wrap 0x0401", 1'b0, 1'b1, 16'h0401, 16'hA5A5, 0);
    check("wrap ram_addr", last_ram_addr, 10'h001);
    do_txn("read 0x0001", 1'b1, 1'b0, 16'h0001, 16'h0000, 0);

    check("req_err before both", {req_err_0, req_err_3}, 2'b00);
    do_txn("both high 0x0010", 1'b1, 1'b1, 16'h0010, 16'h7777, 0);
    check("req_err after both", {req_err_0, req_err_3}, 2'b11);
    do_txn("read 0x0010", 1'b1, 1'b0, 16'h0010, 16'h0000, 0);
    check("req_err sticky", {req_err_0, req_err_3}, 2'b11);

    do_txn("read held past ready", 1'b1, 1'b0, 16'h0005, 16'h0000, 3);

`ifdef MEMCTL_MMIO_EN
    do_txn("io write 0xFF00", 1'b0, 1'b1, 16'hFF00, 16'h00C3, 0);
    check("io_out ws0", io_out_0, 16'h00C3);
    check("io_out ws3", io_out_3, 16'h00C3);
    do_txn("io read 0xFF10", 1'b1, 1'b0, 16'hFF10, 16'h0000, 0);
`else
    check("io_out tied low", {io_out_0, io_out_3}, 0);
`endif

    // Abort a read while the 3-wait-state responder sits in WAIT.
    mem_read = 1'b1; mem_addr = 16'h0005;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort mem_ready", {mem_ready_0, mem_ready_3}, 0);
    check("abort ram_en", {ram_en_0, ram_en_3}, 0);
    check("abort mem_rdata", {mem_rdata_0, mem_rdata_3}, 0);
    check("abort req_err cleared", {req_err_0, req_err_3}, 0);
    check("abort ram_addr", {ram_addr_0, ram_addr_3}, 0);
    last_rd = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_read = 1'b0;
    @(posedge clk); #1;
    do_txn("read after abort", 1'b1, 1'b0, 16'h0005, 16'h0000, 0);
    do_txn("write after abort", 1'b0, 1'b1, 16'h0002, 16'h0F0F, 0);
    do_txn("read 0x0002", 1'b1, 1'b0, 16'h0002, 16'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
